// File: rtl/fu_result_buffer.sv
// Two-entry result buffer between a function unit and writeback: captures the
// result, flags and branch decision at push time and presents them in arrival order.
module fu_result_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_F,
  input  logic        in_V,
  input  logic        in_C,
  input  logic        in_N,
  input  logic        in_Z,
  input  logic        in_LessU,
  input  logic [4:0]  in_rd,
  input  logic        in_wr_en,
  input  logic        in_is_branch,
  input  logic [2:0]  in_br_op,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wr_en,
  output logic        out_taken,
  output logic [3:0]  out_flags,
  output logic [1:0]  count,
  output logic [15:0] taken_cnt
);

  logic [1:0][31:0] result_r;
  logic [1:0][4:0]  rd_r;
  logic [1:0]       wr_en_r;
  logic [1:0]       taken_r;
  logic [1:0][3:0]  flags_r;
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic [15:0]      taken_cnt_r;
  logic             push_s;
  logic             pop_s;
  logic             taken_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  assign out_result = result_r[rd_ptr_r];
  assign out_rd     = rd_r[rd_ptr_r];
  assign out_wr_en  = wr_en_r[rd_ptr_r];
  assign out_taken  = taken_r[rd_ptr_r];
  assign out_flags  = flags_r[rd_ptr_r];
  assign count      = count_r;
  assign taken_cnt  = taken_cnt_r;

  // Branch decision from the subtract flags of the incoming result
  always_comb begin
    taken_s = 1'b0;
    if (in_is_branch) begin
      case (in_br_op)
        3'b000:  taken_s = in_Z;
        3'b001:  taken_s = ~in_Z;
        3'b100:  taken_s = in_N ^ in_V;
        3'b101:  taken_s = ~(in_N ^ in_V);
        3'b110:  taken_s = in_LessU;
        3'b111:  taken_s = ~in_LessU;
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
  end

  // Entry storage, written at the tail on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= '0;
      rd_r     <= '0;
      wr_en_r  <= 2'b00;
      taken_r  <= 2'b00;
      flags_r  <= '0;
    end else if (push_s && !flush) begin
      result_r[wr_ptr_r] <= in_F;
      rd_r[wr_ptr_r]     <= in_rd;
      wr_en_r[wr_ptr_r]  <= in_wr_en && !in_is_branch;
      taken_r[wr_ptr_r]  <= taken_s;
      flags_r[wr_ptr_r]  <= {in_V, in_C, in_N, in_Z};
    end
  end

  // Pointers and occupancy; flush overrides any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating count of popped taken branches; a pop during flush still counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_r <= 16'd0;
    end else if (pop_s && out_taken && (taken_cnt_r != 16'hFFFF)) begin
      taken_cnt_r <= taken_cnt_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_fu_result_buffer.sv
// Directed self-checking bench for fu_result_buffer.
module tb_fu_result_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_F;
  logic        in_V, in_C, in_N, in_Z, in_LessU;
  logic [4:0]  in_rd;
  logic        in_wr_en;
  logic        in_is_branch;
  logic [2:0]  in_br_op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        out_taken;
  logic [3:0]  out_flags;
  logic [1:0]  count;
  logic [15:0] taken_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  fu_result_buffer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_F(in_F), .in_V(in_V), .in_C(in_C), .in_N(in_N), .in_Z(in_Z),
    .in_LessU(in_LessU), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_is_branch(in_is_branch), .in_br_op(in_br_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_taken(out_taken),
    .out_flags(out_flags), .count(count), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {is_br, op[2:0], V, N, Z, LessU, wr_en, exp_taken, exp_wr_en}
  localparam logic [10:0] VEC [13] = '{
    11'b1_001_0000_1_1_0,  // BNE  Z=0 -> taken
    11'b1_001_0010_1_0_0,  // BNE  Z=1
    11'b1_101_0100_0_0_0,  // BGE  N=1 V=0
    11'b1_101_1100_0_1_0,  // BGE  N=1 V=1 -> taken
    11'b1_100_0100_0_1_0,  // BLT  N=1 V=0 -> taken
    11'b1_111_0000_0_1_0,  // BGEU LessU=0 -> taken
    11'b1_111_0001_0_0_0,  // BGEU LessU=1
    11'b1_110_0000_0_0_0,  // BLTU LessU=0
    11'b1_010_0010_0_0_0,  // op 010 never taken
    11'b1_011_0001_0_0_0,  // op 011 never taken
    11'b0_001_0000_1_0_1,  // non-branch keeps wr_en
    11'b0_000_0010_0_0_0,  // non-branch, no write
    11'b1_000_0000_1_0_0   // BEQ  Z=0
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] f, input logic [3:0] vcnz,
                     input logic lu, input logic [4:0] rd, input logic we,
                     input logic br, input logic [2:0] op);
    in_valid = v; in_F = f;
    in_V = vcnz[3]; in_C = vcnz[2]; in_N = vcnz[1]; in_Z = vcnz[0];
    in_LessU = lu; in_rd = rd; in_wr_en = we; in_is_branch = br; in_br_op = op;
  endtask

  initial begin
    logic [10:0] e;
    logic        c;
    int          exp_tc;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drv(1'b0, 32'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0);

    // Reset state before any clock edge
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_out_result", out_result, 32'd0);

    // Release reset and present BLT (N=1,V=1 -> not taken) for the first edge
    #9;
    rst_n = 1'b1;
    drv(1'b1, 32'h10, 4'b1010, 1'b0, 5'd1, 1'b1, 1'b1, 3'b100);
    cyc();
    chk("blt_out_valid", 32'(out_valid), 32'd1);
    chk("blt_taken", 32'(out_taken), 32'd0);
    chk("blt_wr_en", 32'(out_wr_en), 32'd0);
    chk("blt_count", 32'(count), 32'd1);
    drv(1'b1, 32'h20, 4'b0000, 1'b1, 5'd2, 1'b1, 1'b1, 3'b110);
    cyc();
    chk("bltu_count2", 32'(count), 32'd2);
    chk("bltu_in_ready", 32'(in_ready), 32'd0);
    chk("bltu_head_blt", out_result, 32'h10);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("bltu_taken", 32'(out_taken), 32'd1);
    chk("bltu_result", out_result, 32'h20);
    chk("bltu_tc0", 32'(taken_cnt), 32'd0);
    cyc();
    chk("su_count0", 32'(count), 32'd0);
    chk("su_taken_cnt", 32'(taken_cnt), 32'd1);
    out_ready = 1'b0;

    // BEQ with Z=1
    drv(1'b1, 32'd0, 4'b0001, 1'b0, 5'd3, 1'b1, 1'b1, 3'b000);
    cyc();
    in_valid = 1'b0;
    chk("beq_out_valid", 32'(out_valid), 32'd1);
    chk("beq_taken", 32'(out_taken), 32'd1);
    chk("beq_wr_en", 32'(out_wr_en), 32'd0);
    chk("beq_flags", 32'(out_flags), 32'h1);
    chk("beq_rd", 32'(out_rd), 32'd3);
    out_ready = 1'b1;
    cyc();
    chk("beq_taken_cnt", 32'(taken_cnt), 32'd2);
    out_ready = 1'b0;
    exp_tc = 2;

    // Branch decode table, one entry at a time
    for (int i = 0; i < 13; i++) begin
      e = VEC[i];
      c = i[0];
      drv(1'b1, 32'h1111_1111 * (i + 1), {e[6], c, e[5], e[4]}, e[3], i[4:0],
          e[2], e[10], e[9:7]);
      cyc();
      in_valid = 1'b0;
      chk("tbl_taken", 32'(out_taken), 32'(e[1]));
      chk("tbl_wr_en", 32'(out_wr_en), 32'(e[0]));
      chk("tbl_flags", 32'(out_flags), 32'({e[6], c, e[5], e[4]}));
      chk("tbl_result", out_result, 32'h1111_1111 * (i + 1));
      chk("tbl_rd", 32'(out_rd), 32'(i));
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      exp_tc += int'(e[1]);
      chk("tbl_taken_cnt", 32'(taken_cnt), 32'(exp_tc));
    end

    // Backpressure: three ADD results with the consumer stalled
    drv(1'b1, 32'h1, 4'd0, 1'b0, 5'd7, 1'b1, 1'b0, 3'd0);
    cyc();
    chk("bp_in_ready1", 32'(in_ready), 32'd1);
    in_F = 32'h2;
    cyc();
    chk("bp_count2", 32'(count), 32'd2);
    chk("bp_in_ready0", 32'(in_ready), 32'd0);
    in_F = 32'h3;
    cyc();
    chk("bp_held_count", 32'(count), 32'd2);
    chk("bp_head1", out_result, 32'h1);
    chk("bp_wr_en", 32'(out_wr_en), 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("bp_head2", out_result, 32'h2);
    chk("bp_count_after_pop", 32'(count), 32'd1);
    // Push of 0x3 and pop of 0x2 in the same cycle at count=1
    cyc();
    in_valid = 1'b0;
    chk("sim_count", 32'(count), 32'd1);
    chk("sim_head3", out_result, 32'h3);
    cyc();
    chk("bp_drained", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Flush at count=2 with a push offered
    drv(1'b1, 32'hA, 4'd0, 1'b0, 5'd8, 1'b1, 1'b0, 3'd0);
    cyc();
    in_F = 32'hB;
    cyc();
    chk("fl_count2", 32'(count), 32'd2);
    flush = 1'b1; in_F = 32'hC;
    cyc();
    chk("fl_count0", 32'(count), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    chk("fl_nothing_stored", 32'(count), 32'd0);

    // Flush at count=1 with a taken head popped and a push offered
    drv(1'b1, 32'd0, 4'b0001, 1'b0, 5'd9, 1'b0, 1'b1, 3'b000);
    cyc();
    flush = 1'b1; out_ready = 1'b1;
    cyc();
    chk("flp_count0", 32'(count), 32'd0);
    chk("flp_taken_cnt", 32'(taken_cnt), 32'(exp_tc + 1));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cyc();
    chk("flp_push_dropped", 32'(out_valid), 32'd0);

    // Reset asserted between edges with two entries buffered
    drv(1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 5'd31, 1'b1, 1'b1, 3'b000);
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("mr_count2", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_out_result", out_result, 32'd0);
    chk("mr_out_rd", 32'(out_rd), 32'd0);
    chk("mr_out_taken", 32'(out_taken), 32'd0);
    chk("mr_out_flags", 32'(out_flags), 32'd0);
    chk("mr_taken_cnt", 32'(taken_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: one taken pop per cycle with a matching push
    drv(1'b1, 32'd0, 4'b0001, 1'b0, 5'd1, 1'b0, 1'b1, 3'b000);
    cyc();
    out_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(taken_cnt), 32'hFFFE);
    cyc();
    chk("sat_ffff", 32'(taken_cnt), 32'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 32'(taken_cnt), 32'hFFFF);
    chk("sat_count", 32'(count), 32'd1);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fu_result_buffer.md
FU_RESULT_BUFFER -- requirements
Module: fu_result_buffer

Interface
REQ-001 The block SHALL have one clock domain, with an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  the function unit result on the in_* bus is valid this cycle.
REQ-005 in_ready  output  1  the buffer accepts an entry this cycle.
REQ-006 in_F  input  32  function unit result F.
REQ-007 in_V, in_C, in_N, in_Z, in_LessU  input  1 each  function unit flags V, C, N, Z and Less_U bit 0.
REQ-008 in_rd  input  5  destination register index.
REQ-009 in_wr_en  input  1  the instruction writes rd.
REQ-010 in_is_branch  input  1  the instruction is a conditional branch; upstream has driven subtract, so F = A-B.
REQ-011 in_br_op  input  3  branch funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-012 flush  input  1  synchronous discard of all buffered entries.
REQ-013 out_valid  output  1  the head entry is valid.
REQ-014 out_ready  input  1  the consumer takes the head entry.
REQ-015 out_result  output  32  F of the head entry.
REQ-016 out_rd  output  5 and out_wr_en  output  1  rd and the effective write enable of the head entry.
REQ-017 out_taken  output  1  branch decision of the head entry.
REQ-018 out_flags  output  4  {V,C,N,Z} of the head entry.
REQ-019 count  output  2  occupancy, 0..2.
REQ-020 taken_cnt  output  16  saturating count of taken branches that have been popped.

Function
REQ-021 Storage SHALL be a 2-entry FIFO in arrival order, holding result, rd, effective wr_en, taken and flags.
REQ-022 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-023 in_ready SHALL be 1 exactly when count<2, and SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-024 out_valid SHALL be 1 exactly when count>0; the out_* outputs SHALL come directly from the head-entry registers.
REQ-025 The latency from a push to out_valid for that entry SHALL be 1 cycle when the buffer is empty.
REQ-026 The taken decision SHALL be evaluated at push time from the in_* flags: BEQ=Z, BNE=~Z, BLT=N^V, BGE=~(N^V), BLTU=LessU, BGEU=~LessU.
REQ-027 br_op values 010 and 011, and any entry with in_is_branch=0, SHALL store taken=0.
REQ-028 The effective wr_en SHALL be in_wr_en && !in_is_branch.
REQ-029 A simultaneous push and pop at count=1 SHALL leave count at 1, with the new entry becoming head on the next cycle.
REQ-030 At count=2 no push SHALL be possible; a pop SHALL make count 1.
REQ-031 A push or pop SHALL have no effect on count beyond the single-step rules above.
REQ-032 Flush SHALL set count to 0 on the next edge, and SHALL drop any push or pop in the same cycle; taken_cnt SHALL still count a same-cycle pop of a taken entry.
REQ-033 taken_cnt SHALL increment by 1 on each pop whose head has taken=1.
REQ-034 taken_cnt SHALL hold at 16'hFFFF and never wrap.
REQ-035 The pointers SHALL wrap modulo 2.

Reset
REQ-036 While rst_n=0, regardless of clk, the block SHALL hold count=0, out_valid=0, in_ready=1, taken_cnt=0, out_result=0, out_rd=0, out_wr_en=0, out_taken=0 and out_flags=0.
REQ-037 A reset asserted mid-operation SHALL discard all entries immediately.
REQ-038 The first push SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-039 BEQ scenario: push BEQ with Z=1, F=0 -> next cycle out_valid=1, out_taken=1, out_wr_en=0, out_flags=4'b0001.
REQ-040 Signed/unsigned scenario: push BLT with N=1, V=1, then BLTU with LessU=1 -> out_taken 0 then 1; taken_cnt=1 after both pops.
REQ-041 Backpressure scenario: out_ready=0, push 3 ADD results (0x1, 0x2, 0x3) -> in_ready=0 after the 2nd push, count=2, the 3rd is held; release out_ready -> outputs 0x1, 0x2, then 0x3 in order.
REQ-042 Simultaneous scenario: at count=1 with push and pop in the same cycle -> count stays 1 and the head becomes the new entry.
REQ-043 Flush/reset scenario: at count=2, flush=1 with in_valid=1 -> count=0 and out_valid=0 next cycle, no entry stored; assert rst_n=0 between clock edges -> outputs are 0 immediately.
REQ-044 Saturation scenario: force 65536 taken-branch pops -> taken_cnt=16'hFFFF, unchanged by further taken pops.
